// File: rtl/ula_pkg.sv
// Shared opcode encodings for the ULA datapath ALU.
// Imported by the combinational core and the registered wrapper.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

endpackage : ula_pkg

// File: rtl/ula_core.sv
// Combinational ALU core: result plus zero/carry/overflow/negative flags
// for the eight ULA operations, with no state of its own.
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] and_vec;
  logic [WIDTH-1:0] or_vec;
  logic [WIDTH-1:0] xor_vec;
  logic [WIDTH-1:0] not_vec;

  // Extra top bit captures carry-out on add and borrow on subtract.
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_vec[gi] = op_a[gi] & op_b[gi];
      assign or_vec[gi]  = op_a[gi] | op_b[gi];
      assign xor_vec[gi] = op_a[gi] ^ op_b[gi];
      assign not_vec[gi] = ~op_a[gi];
    end
  endgenerate

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (select)
      OP_ADD: begin
        {carry, result} = sum_ext;
        ovf = (op_a[MSB] == op_b[MSB]) && (sum_ext[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        {carry, result} = diff_ext;
        ovf = (op_a[MSB] != op_b[MSB]) && (diff_ext[MSB] != op_a[MSB]);
      end
      OP_AND: result = and_vec;
      OP_OR:  result = or_vec;
      OP_XOR: result = xor_vec;
      OP_NOT: result = not_vec;
      OP_SHL: begin
        result = {op_a[MSB-1:0], 1'b0};
        carry  = op_a[MSB];
      end
      OP_SHR: begin
        result = {1'b0, op_a[MSB:1]};
        carry  = op_a[0];
      end
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[MSB];

endmodule : ula_core

// File: rtl/ula_alu.sv
// Registered ALU between register-file read ports and write-back mux:
// one-cycle latency, result/flags hold whenever in_valid is low.
module ula_alu
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       select,
  output logic             out_valid,
  output logic [WIDTH-1:0] saida,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_neg
);

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_ovf;
  logic             core_zero;
  logic             core_neg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] saida_reg;
  logic             zero_reg;
  logic             carry_reg;
  logic             ovf_reg;
  logic             neg_reg;

  ula_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_a   (op_a),
    .op_b   (op_b),
    .select (select),
    .result (core_result),
    .carry  (core_carry),
    .ovf    (core_ovf),
    .zero   (core_zero),
    .neg    (core_neg)
  );

  // Reset takes priority and drops any result still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      saida_reg     <= '0;
      zero_reg      <= 1'b0;
      carry_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      neg_reg       <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        saida_reg <= core_result;
        zero_reg  <= core_zero;
        carry_reg <= core_carry;
        ovf_reg   <= core_ovf;
        neg_reg   <= core_neg;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign saida      = saida_reg;
  assign flag_zero  = zero_reg;
  assign flag_carry = carry_reg;
  assign flag_ovf   = ovf_reg;
  assign flag_neg   = neg_reg;

endmodule : ula_alu

// File: tb/tb_ula_alu.sv
// Self-checking bench for ula_alu: directed test-plan vectors, hold and
// reset cases, then randomized traffic against an arithmetic reference model.
module tb_ula_alu;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   select;
  logic         out_valid;
  logic [W-1:0] saida;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;
  logic         flag_neg;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should show after the last edge.
  int m_valid, m_saida, m_carry, m_ovf, m_zero, m_neg;

  ula_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .op_a       (op_a),
    .op_b       (op_b),
    .select     (select),
    .out_valid  (out_valid),
    .saida      (saida),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .flag_neg   (flag_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // Operation semantics from plain integer arithmetic.
  task automatic ref_op(input int a, input int b, input int sel,
                        output int res, output int c, output int o);
    int s;
    c = 0;
    o = 0;
    case (sel)
      0: begin
        s   = a + b;
        res = s % M;
        c   = (s >= M) ? 1 : 0;
        s   = to_signed(a) + to_signed(b);
        o   = (s > M / 2 - 1 || s < -(M / 2)) ? 1 : 0;
      end
      1: begin
        res = (a - b + M) % M;
        c   = (a < b) ? 1 : 0;
        s   = to_signed(a) - to_signed(b);
        o   = (s > M / 2 - 1 || s < -(M / 2)) ? 1 : 0;
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (M - 1) - a;
      6: begin res = (a * 2) % M; c = (a >= M / 2) ? 1 : 0; end
      default: begin res = a / 2; c = a % 2; end
    endcase
  endtask

  // Drive one cycle on the falling edge, advance the model at the rising
  // edge, then compare every output shortly after it.
  task automatic cycle(input bit rst, input bit v, input int a, input int b, input int sel);
    int r, c, o;
    @(negedge clk);
    rst_n    = !rst;
    in_valid = v;
    op_a     = W'(a);
    op_b     = W'(b);
    select   = 3'(sel);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_saida = 0; m_carry = 0; m_ovf = 0; m_zero = 0; m_neg = 0;
    end else begin
      m_valid = v;
      if (v) begin
        ref_op(a, b, sel, r, c, o);
        m_saida = r;
        m_carry = c;
        m_ovf   = o;
        m_zero  = (r == 0) ? 1 : 0;
        m_neg   = (r >= M / 2) ? 1 : 0;
      end
    end
    $display("cyc rst=%0b v=%0b sel=%0d a=%0d b=%0d -> ov=%0b s=%0d z%0b c%0b o%0b n%0b",
             rst, v, sel, a, b, out_valid, saida, flag_zero, flag_carry, flag_ovf, flag_neg);
    chk("out_valid", int'(out_valid), m_valid);
    chk("saida", int'(saida), m_saida);
    chk("flag_carry", int'(flag_carry), m_carry);
    chk("flag_ovf", int'(flag_ovf), m_ovf);
    chk("flag_zero", int'(flag_zero), m_zero);
    chk("flag_neg", int'(flag_neg), m_neg);
  endtask

  typedef struct {
    int a, b, sel, res, c, o, z, n;
  } vec_t;

  vec_t plan[10] = '{
    '{12,  3, 0, 15, 0, 0, 0, 1},
    '{15,  1, 0,  0, 1, 0, 1, 0},
    '{11, 15, 1, 12, 1, 0, 0, 1},
    '{ 7,  8, 1, 15, 1, 1, 0, 1},
    '{ 0, 15, 2,  0, 0, 0, 1, 0},
    '{12, 15, 3, 15, 0, 0, 0, 1},
    '{10,  3, 4,  9, 0, 0, 0, 1},
    '{10, 11, 5,  5, 0, 0, 0, 0},
    '{ 9,  2, 6,  2, 1, 0, 0, 0},
    '{10,  6, 7,  5, 0, 0, 0, 0}
  };

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; select = '0;
    m_valid = 0; m_saida = 0; m_carry = 0; m_ovf = 0; m_zero = 0; m_neg = 0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 5, 5, 0);

    // Test-plan vectors back to back, also checked against literal answers.
    foreach (plan[i]) begin
      cycle(0, 1, plan[i].a, plan[i].b, plan[i].sel);
      chk("plan_saida", int'(saida), plan[i].res);
      chk("plan_carry", int'(flag_carry), plan[i].c);
      chk("plan_ovf", int'(flag_ovf), plan[i].o);
      chk("plan_zero", int'(flag_zero), plan[i].z);
      chk("plan_neg", int'(flag_neg), plan[i].n);
    end

    // Hold: invalid cycle with changed operands keeps the SHR result.
    cycle(0, 0, 3, 9, 0);
    chk("hold_valid", int'(out_valid), 0);
    chk("hold_saida", int'(saida), 5);

    // Reset mid-stream wins over in_valid, then first result after release.
    cycle(0, 1, 12, 3, 0);
    cycle(1, 1, 15, 1, 0);
    chk("rst_saida", int'(saida), 0);
    cycle(0, 0, 15, 1, 0);
    chk("post_rst_idle", int'(out_valid), 0);
    cycle(0, 1, 7, 8, 1);
    chk("post_rst_result", int'(saida), 15);

    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
            int'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ula_alu

// File: doc/ula_alu.md
Name: ula_alu

Overview:
- Registered 4-bit (parameterisable) arithmetic/logic unit for the datapath.
- Takes two operands and a 3-bit operation select, and computes one of eight operations.
- Presents the result and status flags one clock later.
- Sits between the register-file read ports and the write-back mux.

Parameters:
- WIDTH, 4, operand/result width in bits (minimum 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operands/select are valid this cycle.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- select  in  3  operation code.
- out_valid  out  1  result/flags updated from a valid input on the previous edge.
- saida  out  WIDTH  registered result.
- flag_zero  out  1  result equals zero.
- flag_carry  out  1  carry/borrow/shifted-out bit.
- flag_ovf  out  1  signed overflow (add/sub only).
- flag_neg  out  1  result MSB.

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous, active-low.
- Reset: on a rising edge with rst_n=0, all outputs go to 0. Reset wins over in_valid in the same cycle. Reset mid-stream discards the pending result.
- Latency: exactly 1 cycle. On a rising edge with rst_n=1:
  - out_valid <= in_valid.
  - If in_valid=1, saida and all flags load the new values.
  - If in_valid=0, saida and flags hold their previous values.
- No backpressure; a new operation can be accepted every cycle.
- Opcodes (result truncated to WIDTH, all arithmetic modulo 2^WIDTH):
  - 000 ADD: A+B. carry = carry-out.
  - 001 SUB: A-B. carry = borrow (1 iff A<B unsigned).
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 XOR: A^B.
  - 101 NOT: ~A. B is ignored.
  - 110 SHL: A<<1, zero fill. carry = A[MSB].
  - 111 SHR: A>>1, logical, zero fill. carry = A[0].
- carry = 0 for all logic ops (010–101).
- flag_ovf: ADD/SUB only, two's-complement overflow. ADD: operand signs equal and result sign differs. SUB: operand signs differ and result sign differs from A. Otherwise 0.
- flag_zero = (result == 0). flag_neg = result[WIDTH-1]. Both apply to all ops.
- X/undefined select is impossible: all eight codes are defined, and the case statement is full.

Decomposition:
- Package ula_pkg: 3-bit opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR.
- Sub-module ula_core: purely combinational; computes result and the four flags from op_a/op_b/select.
- ula_alu: wraps ula_core with the valid/output registers and reset.

Test Plan (WIDTH=4, in_valid=1, check outputs one cycle later):
- ADD 1100+0011 -> saida=1111, carry=0, ovf=0, zero=0, neg=1. ADD 1111+0001 -> 0000, carry=1, zero=1.
- SUB 1011-1111 -> saida=1100, carry=1, ovf=0, neg=1. SUB 0111-1000 -> 1111, ovf=1.
- Logic ops:
  - AND 0000&1111 -> 0000, zero=1.
  - OR 1100|1111 -> 1111.
  - XOR 1010^0011 -> 1001.
  - NOT 1010 (B=1011) -> 0101, carry=0.
- Shifts: SHL 1001 (B=0010) -> 0010, carry=1. SHR 1010 (B=0110) -> 0101, carry=0.
- Valid/hold: drive one op, then in_valid=0 with changed operands -> out_valid=0, saida and flags unchanged. Back-to-back valid ops produce results on consecutive cycles.
- Reset: assert rst_n=0 with in_valid=1 mid-stream -> next edge gives all outputs 0. Release -> first result appears one cycle after the next valid input.
